// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand bypass selection and load-use stall detection
// driven by a shadow pipeline of in-flight register writes.
module fwd_hazard_unit #(
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                advance,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [NSRC*5-1:0]   id_src_reg,
    input  logic [NSRC-1:0]     id_src_used,
    input  logic                id_dst_we,
    input  logic [4:0]          id_dst_reg,
    input  logic [1:0]          id_dst_kind,
    output logic [NSRC*SW-1:0]  fwd_stage,
    output logic [NSRC*2-1:0]   fwd_kind,
    output logic                stall,
    output logic [15:0]         stall_cnt
);
    typedef enum logic {ST_RUN, ST_STALL} state_t;
    state_t state, nxt_state;
    logic [DEPTH:1] t_valid, t_we;
    logic [4:0] t_reg [1:DEPTH];
    logic [1:0] t_kind [1:DEPTH];
    logic [NSRC-1:0] hazard;
    logic [1:0] new_kind;
    logic cnt_inc;
    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        fwd_stage = '0;
        fwd_kind  = '0;
        hazard    = '0;
        for (int i = 0; i < NSRC; i++)
            for (int k = DEPTH; k >= 1; k--)
                if (t_valid[k] && t_we[k] && t_reg[k] != 5'd0 && t_reg[k] == id_src_reg[5*i +: 5]
                    && id_valid && id_src_used[i]) begin
                    fwd_stage[SW*i +: SW] = SW'(k);
                    fwd_kind[2*i +: 2]    = t_kind[k];
                    hazard[i]             = t_kind[k] == 2'b01 && k < LOAD_READY;
                end
    end
    assign stall    = |hazard && advance && !flush;
    assign new_kind = id_dst_kind == 2'b11 ? 2'b00 : id_dst_kind;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_RUN;
        else
            state <= nxt_state;
    end
    always_comb begin
        nxt_state = state == ST_RUN ? (stall && advance ? ST_STALL : ST_RUN)
                                    : (stall ? ST_STALL : ST_RUN);
    end
    always_comb begin
        cnt_inc = nxt_state == ST_STALL && stall_cnt != 16'hFFFF;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_valid   <= '0;
            t_we      <= '0;
            stall_cnt <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                t_reg[k]  <= '0;
                t_kind[k] <= '0;
            end
        end else if (advance) begin
            for (int k = DEPTH; k >= 2; k--) begin
                t_valid[k] <= t_valid[k-1];
                t_we[k]    <= t_we[k-1];
                t_reg[k]   <= t_reg[k-1];
                t_kind[k]  <= t_kind[k-1];
            end
            t_valid[1] <= id_valid && !flush && !stall;
            t_we[1]    <= id_dst_we;
            t_reg[1]   <= id_dst_reg;
            t_kind[1]  <= new_kind;
            stall_cnt  <= stall_cnt + 16'(cnt_inc);
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed bench for the default and a deeper configuration,
// checked every cycle against a queue-style model plus literal expectations.
module tb_fwd_hazard_unit;
    logic clk = 0, reset_n = 0, advance = 1, flush = 0, id_valid = 0, id_dst_we = 0;
    logic [9:0] id_src_reg = '0;
    logic [1:0] id_src_used = '0, id_dst_kind = '0;
    logic [4:0] id_dst_reg = '0;
    logic [3:0] fs_a, fk_a, fk_b;
    logic [5:0] fs_b;
    logic st_a, st_b;
    logic [15:0] cnt_a, cnt_b;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut_a (
        .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush), .id_valid(id_valid),
        .id_src_reg(id_src_reg), .id_src_used(id_src_used), .id_dst_we(id_dst_we),
        .id_dst_reg(id_dst_reg), .id_dst_kind(id_dst_kind),
        .fwd_stage(fs_a), .fwd_kind(fk_a), .stall(st_a), .stall_cnt(cnt_a)
    );

    fwd_hazard_unit #(.DEPTH(4), .LOAD_READY(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush), .id_valid(id_valid),
        .id_src_reg(id_src_reg), .id_src_used(id_src_used), .id_dst_we(id_dst_we),
        .id_dst_reg(id_dst_reg), .id_dst_kind(id_dst_kind),
        .fwd_stage(fs_b), .fwd_kind(fk_b), .stall(st_b), .stall_cnt(cnt_b)
    );

    typedef struct packed {logic v; logic we; logic [4:0] r; logic [1:0] kind;} ent_t;
    ent_t ent [0:1][1:4];
    int mcnt [0:1];

    function automatic int dep(input int u);
        return u == 0 ? 3 : 4;
    endfunction

    function automatic int lrdy(input int u);
        return u == 0 ? 2 : 3;
    endfunction

    // Stage of the youngest in-flight writer of operand i, 0 if none.
    function automatic int win(input int u, input int i);
        logic [4:0] s;
        s = id_src_reg[5*i +: 5];
        if (!id_valid || !id_src_used[i] || s == 5'd0) return 0;
        for (int k = 1; k <= dep(u); k++)
            if (ent[u][k].v && ent[u][k].we && ent[u][k].r == s) return k;
        return 0;
    endfunction

    function automatic int mkind(input int u, input int i);
        int w;
        w = win(u, i);
        return w == 0 ? 0 : int'(ent[u][w].kind);
    endfunction

    function automatic logic mstall(input int u);
        logic hz;
        int w;
        hz = 0;
        for (int i = 0; i < 2; i++) begin
            w = win(u, i);
            if (w != 0 && ent[u][w].kind == 2'b01 && w < lrdy(u)) hz = 1;
        end
        return hz && advance && !flush;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int u = 0; u < 2; u++) begin
                mcnt[u] <= 0;
                for (int k = 1; k <= 4; k++) ent[u][k] <= '0;
            end
        end else if (advance) begin
            for (int u = 0; u < 2; u++) begin
                for (int k = 2; k <= dep(u); k++) ent[u][k] <= ent[u][k-1];
                ent[u][1] <= mstall(u) ? ent_t'(0) :
                    ent_t'({id_valid && !flush, id_dst_we, id_dst_reg,
                            id_dst_kind == 2'b11 ? 2'b00 : id_dst_kind});
                if (mstall(u) && mcnt[u] < 65535) mcnt[u] <= mcnt[u] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("model%0d_stall", u), u != 0 ? int'(st_b) : int'(st_a), int'(mstall(u)));
            chk($sformatf("model%0d_cnt", u), u != 0 ? int'(cnt_b) : int'(cnt_a), mcnt[u]);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model%0d_stage%0d", u, i),
                    u != 0 ? int'(fs_b[3*i +: 3]) : int'(fs_a[2*i +: 2]), win(u, i));
                chk($sformatf("model%0d_kind%0d", u, i),
                    u != 0 ? int'(fk_b[2*i +: 2]) : int'(fk_a[2*i +: 2]), mkind(u, i));
            end
        end
    end

    task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic we, input logic [4:0] dst,
                          input logic [1:0] kind);
        id_valid = v;
        id_src_reg = {s1, s0};
        id_src_used = used;
        id_dst_we = we;
        id_dst_reg = dst;
        id_dst_kind = kind;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int bs;
        repeat (2) cyc;
        set_id(1, 8, 8, 3, 1, 9, 1);
        @(negedge clk);
        chk("rst_stall", st_a, 0);
        chk("rst_stage", fs_a, 0);
        chk("rst_kind", fk_a, 0);
        chk("rst_cnt", cnt_a, 0);
        cyc;
        reset_n = 1;
        nops(2);
        // ALU producer followed by a dual-operand consumer
        set_id(1, 0, 0, 0, 1, 8, 0); cyc;
        set_id(1, 8, 8, 3, 1, 9, 0);
        @(negedge clk);
        chk("alu_stage0", fs_a[1:0], 1);
        chk("alu_stage1", fs_a[3:2], 1);
        chk("alu_kind", fk_a, 0);
        chk("alu_stall", st_a, 0);
        cyc; nops(3);
        // illegal kind 11 behaves as ALU
        set_id(1, 0, 0, 0, 1, 7, 3); cyc;
        set_id(1, 7, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("k11_stage0", fs_a[1:0], 1);
        chk("k11_kind0", fk_a[1:0], 0);
        chk("k11_stall", st_a, 0);
        cyc; nops(3);
        // load-use
        set_id(1, 0, 0, 0, 1, 8, 1); cyc;
        set_id(1, 8, 0, 3, 1, 9, 0);
        @(negedge clk);
        chk("lu_stall", st_a, 1);
        chk("lu_stage0", fs_a[1:0], 1);
        chk("lu_kind0", fk_a[1:0], 1);
        chk("lu_stage1_r0", fs_a[3:2], 0);
        cyc;
        @(negedge clk);
        chk("lu_stall_after", st_a, 0);
        chk("lu_cnt", cnt_a, 1);
        chk("lu_stage0_after", fs_a[1:0], 2);
        chk("lu_kind0_after", fk_a[1:0], 1);
        cyc; nops(3);
        // youngest producer wins
        set_id(1, 0, 0, 0, 1, 5, 0); cyc;
        set_id(1, 0, 0, 0, 1, 5, 1); cyc;
        set_id(1, 0, 0, 0, 1, 31, 2); cyc;
        set_id(1, 5, 31, 3, 1, 10, 0);
        @(negedge clk);
        chk("yw_stage0", fs_a[1:0], 2);
        chk("yw_kind0", fk_a[1:0], 1);
        chk("yw_stage1", fs_a[3:2], 1);
        chk("yw_kind1", fk_a[3:2], 2);
        chk("yw_stall", st_a, 0);
        cyc; nops(4);
        // writes to $0 are never forwarded
        set_id(1, 0, 0, 0, 1, 0, 1); cyc;
        set_id(1, 0, 0, 3, 1, 9, 0);
        @(negedge clk);
        chk("r0_stage", fs_a, 0);
        chk("r0_stall", st_a, 0);
        cyc; nops(3);
        // freeze during a pending hazard
        set_id(1, 0, 0, 0, 1, 8, 1); cyc;
        set_id(1, 8, 0, 1, 1, 9, 0);
        advance = 0;
        repeat (5) begin
            @(negedge clk);
            chk("fz_stall", st_a, 0);
            chk("fz_cnt", cnt_a, 1);
            chk("fz_stage0", fs_a[1:0], 1);
            chk("fz_kind0", fk_a[1:0], 1);
            cyc;
        end
        advance = 1;
        @(negedge clk);
        chk("fz_stall_release", st_a, 1);
        cyc;
        @(negedge clk);
        chk("fz_stall_done", st_a, 0);
        chk("fz_cnt_after", cnt_a, 2);
        chk("fz_stage0_after", fs_a[1:0], 2);
        cyc; nops(4);
        // flush beats a hazard
        set_id(1, 0, 0, 0, 1, 8, 1); cyc;
        set_id(1, 8, 0, 1, 1, 9, 0);
        flush = 1;
        @(negedge clk);
        chk("fl_stall", st_a, 0);
        chk("fl_cnt", cnt_a, 2);
        cyc;
        flush = 0;
        set_id(1, 9, 8, 3, 0, 0, 0);
        @(negedge clk);
        chk("fl_bubble_stage0", fs_a[1:0], 0);
        chk("fl_stage1", fs_a[3:2], 2);
        chk("fl_cnt_after", cnt_a, 2);
        cyc; nops(4);
        // reset while the deeper instance sits in its stall
        set_id(1, 0, 0, 0, 1, 8, 1); cyc;
        set_id(1, 8, 0, 1, 1, 9, 0);
        @(negedge clk);
        chk("rs_stall_a", st_a, 1);
        cyc;
        @(negedge clk);
        chk("rs_stall_b", st_b, 1);
        #2 reset_n = 0;
        #1;
        chk("rs_async_stall_b", st_b, 0);
        chk("rs_async_stage_b", fs_b, 0);
        chk("rs_async_kind_b", fk_b, 0);
        chk("rs_async_cnt_a", cnt_a, 0);
        chk("rs_async_cnt_b", cnt_b, 0);
        cyc;
        reset_n = 1;
        @(negedge clk);
        chk("rs_post_stall_a", st_a, 0);
        chk("rs_post_stall_b", st_b, 0);
        cyc; nops(4);
        // back-to-back load-use costs two cycles in the deeper instance
        set_id(1, 0, 0, 0, 1, 8, 1); cyc;
        set_id(1, 8, 0, 1, 1, 9, 0);
        bs = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!st_b) break;
            bs++;
            cyc;
        end
        cyc;
        chk("d4_stall_len", bs, 2);
        chk("d4_cnt_b", cnt_b, 2);
        chk("d4_cnt_a", cnt_a, 1);
        nops(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the MIPS pipeline. It tracks every in-flight register write in an internal shadow pipeline of `DEPTH` stages and selects, per source operand, the youngest producing stage and its result kind. It raises a load-use stall when a result is not yet available, inserting bubbles until it is. It sits beside the ID stage and drives the bypass muxes feeding the ALU, branch and jr paths.

## Interface
- `NSRC`, 2: source operands checked per decoded instruction.
- `DEPTH`, 3: in-flight stages tracked after ID (1 = EX, 2 = MEM, 3 = WB).
- `LOAD_READY`, 2: first stage index whose memory-load result is forwardable.
- `SW`, `$clog2(DEPTH+1)`: width of one stage-select field.
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `advance` input 1: global pipeline enable; 0 freezes the tracker.
- `flush` input 1: kill the instruction in ID; it enters the tracker as a bubble.
- `id_valid` input 1: ID holds a real instruction.
- `id_src_reg` input `NSRC*5`: source register numbers, operand i at bits [5i+4:5i].
- `id_src_used` input `NSRC`: operand i is actually read.
- `id_dst_we` input 1: ID instruction writes a register.
- `id_dst_reg` input 5: destination register.
- `id_dst_kind` input 2: result kind, 00 = ALU, 01 = memory load, 10 = PC+4; 11 is illegal and treated as 00.
- `fwd_stage` output `NSRC*SW`: per operand, 0 = register file, k = forward from stage k.
- `fwd_kind` output `NSRC*2`: per operand, kind of the selected producer (00 when `fwd_stage` = 0).
- `stall` output 1: hold PC and IF/ID; a bubble is inserted into stage 1.
- `stall_cnt` output 16: saturating count of stall cycles since reset.

## Operation
- **Tracker.** Each of the `DEPTH` entries holds {valid, we, reg[4:0], kind[1:0]}. Entry 1 is the youngest.
- **Match for operand i.** Entry k matches when it is valid, `we` = 1, `reg` ≠ 0, `reg` = src_i, `id_valid` = 1 and `id_src_used[i]` = 1.
  - The lowest matching k wins (youngest producer).
  - With no match, `fwd_stage` = 0 and `fwd_kind` = 00.
- **Hazard for operand i.** The winning entry has kind 01 and k < `LOAD_READY`. Kinds 00 and 10 are ready at every k ≥ 1. Only the winning entry is considered, so an older ready duplicate never masks a younger unready one.
- `stall` = OR of all operand hazards, AND `advance`, AND NOT `flush`.
- While operand i is hazarded, `fwd_stage`/`fwd_kind` still report the winner. Consumers ignore them while `stall` = 1.
- **FSM, RUN → STALL.** Taken when `stall` = 1 and `advance` = 1.
  - STALL stays while `stall` remains 1.
  - STALL returns to RUN the first cycle `stall` = 0.
  - The state is exported only through `stall_cnt` behaviour.
- **Tracker update on clock edge.**
  - `advance` = 0: all entries and `stall_cnt` hold.
  - `advance` = 1, `stall` = 1: entries 1..DEPTH−1 shift to 2..DEPTH, and entry 1 becomes invalid (bubble).
  - `advance` = 1, `stall` = 0: same shift, and entry 1 loads {`id_valid` & !`flush`, `id_dst_we`, `id_dst_reg`, kind}.
- `stall_cnt` increments on every edge with `advance` & `stall`. It saturates at 0xFFFF.
- Register 0 is never forwarded and never causes a stall.

## Timing
- `fwd_stage`, `fwd_kind` and `stall` are combinational from the ID inputs and tracker state, valid in the same cycle.
- The tracker and `stall_cnt` update on the rising edge.
- A load-use stall lasts `LOAD_READY`−k cycles, where k is the producer's stage at detection. With defaults, a back-to-back load-use costs exactly 1 cycle.
- **Reset values.**
  - All entries invalid, FSM = RUN, `stall_cnt` = 0.
  - Hence `stall` = 0, `fwd_stage` = 0 and `fwd_kind` = 00 regardless of the ID inputs.
- **Reset mid-stall.** Tracker and counter clear immediately and asynchronously. The first edge after deassertion behaves as from RUN.
- **flush together with a hazard.** `flush` wins: no stall, the bubble enters, and the counter does not increment.
- **Both operands hit the same producer.** Both report the same stage and kind, and a single stall covers both.

## Test plan
- **ALU back-to-back.** `add $8` then `sub $9,$8,$8` → operands 0 and 1 give `fwd_stage` = 1, `fwd_kind` = 00, `stall` = 0.
- **Load-use.** `lw $8` then `add $9,$8,$0` → `stall` = 1 for 1 cycle and `stall_cnt` = 1. The next cycle gives `fwd_stage` = 2, `fwd_kind` = 01.
- **Youngest wins / $0 ignored.**
  - `addi $5` (stage 3), `lw $5` (stage 2), `jal` writing $31 (stage 1), then `or $10,$5,$31` → operand 0: stage 2, kind 01. Operand 1: stage 1, kind 10. No stall.
  - A separate case writing $0 → stage 0.
- **Freeze.** `advance` = 0 for 5 cycles during a pending hazard → entries unchanged, `stall` = 0, `stall_cnt` unchanged. Restoring `advance` → the 1-cycle stall occurs.
- **Flush vs hazard.** Load-use with `flush` = 1 → `stall` = 0 and entry 1 invalid next cycle.
- **Reset mid-stall.** Assert `reset_n` = 0 during STALL → all outputs 0 asynchronously and `stall_cnt` = 0. Also run with `DEPTH` = 4, `LOAD_READY` = 3: a back-to-back load-use → a 2-cycle stall.
